// File: rtl/board_pkg.sv
// Board-level ROM region table and shared types for the region uploader.
// Region geometry lives here only; the uploader has no parameters of its own.
package board_pkg;

    typedef struct packed {
        logic [24:0] base_addr;
        logic        reorder_64;
        logic [4:0]  bram_cs;
        logic [23:0] size;
    } upload_region_t;

    localparam int NUM_UPLOAD_REGIONS = 5;
    localparam int IDX_W              = $clog2(NUM_UPLOAD_REGIONS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UPLOAD_REGIONS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Regions with a nonzero bram_cs or zero size are never streamed.
    localparam upload_region_t [0:NUM_UPLOAD_REGIONS-1] UPLOAD_REGIONS = '{
        '{base_addr: 25'h0000100, reorder_64: 1'b0, bram_cs: 5'd0, size: 24'd4},
        '{base_addr: 25'h0001000, reorder_64: 1'b0, bram_cs: 5'd1, size: 24'd16},
        '{base_addr: 25'h0002000, reorder_64: 1'b0, bram_cs: 5'd0, size: 24'd0},
        '{base_addr: 25'h0000200, reorder_64: 1'b0, bram_cs: 5'd0, size: 24'd3},
        '{base_addr: 25'h0010000, reorder_64: 1'b1, bram_cs: 5'd0, size: 24'd128}
    };

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG,
        ST_REG_SEL,
        ST_HDR,
        ST_FETCH,
        ST_WAIT_RDY,
        ST_EMIT_LO,
        ST_EMIT_HI,
        ST_TERM,
        ST_DONE
    } upl_state_e;

endpackage

// File: rtl/rom_region_uploader_if.sv
// Byte-stream output and SDR read-port signals of the ROM region uploader.
interface rom_region_uploader_if;
    logic        data_wait;
    logic        data_strobe;
    logic [7:0]  data;
    logic [24:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_rdy;
    logic [15:0] sdr_dout;

    modport master (
        input  data_wait, sdr_rdy, sdr_dout,
        output data_strobe, data, sdr_addr, sdr_req
    );

    modport slave (
        output data_wait, sdr_rdy, sdr_dout,
        input  data_strobe, data, sdr_addr, sdr_req
    );
endinterface

// File: rtl/rom_addr_map.sv
// Byte-offset remap for ROM regions; also usable by the ROM loader path.
module rom_addr_map (
    input  logic [24:0] offset_i,
    input  logic        reorder_64_i,
    output logic [24:0] mapped_o
);
    // Reordered layout moves offset bit 6 down to bit 2 and shifts bits 5:2 up by one.
    assign mapped_o = reorder_64_i ? {offset_i[24:7], offset_i[5:2], offset_i[6], offset_i[1:0]}
                                   : offset_i;
endmodule

// File: rtl/rom_region_uploader.sv
// Streams the board config byte, each uploadable ROM region (index, size, data)
// read from SDRAM, and a four-byte zero terminator to a back-pressured consumer.
module rom_region_uploader
    import board_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            board_cfg_byte,
    output logic                  busy,
    rom_region_uploader_if.master bus
);

    upl_state_e        state_q, state_d;
    logic [7:0]        cfg_q, cfg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       rem_q, rem_d;
    logic [24:0]       off_q, off_d;
    logic [24:0]       base_q, base_d;
    logic              reorder_q, reorder_d;
    logic [15:0]       word_q, word_d;
    logic [7:0]        data_q, data_d;
    logic              pend_q, pend_d;
    logic              req_q, req_d;
    logic [24:0]       addr_q, addr_d;

    upload_region_t    region;
    logic              past_last;
    logic              uploadable;
    logic              strobe;
    logic              slot_free;
    logic              load;
    logic [7:0]        load_byte;
    logic [24:0]       mapped;

    rom_addr_map u_addr_map (
        .offset_i     (off_q),
        .reorder_64_i (reorder_q),
        .mapped_o     (mapped)
    );

    assign past_last  = idx_q > LAST_IDX;
    assign region     = past_last ? upload_region_t'(0) : UPLOAD_REGIONS[idx_q];
    assign uploadable = (region.bram_cs == 5'd0) && (region.size != 24'd0);

    // A loaded byte waits in data_q until the consumer is ready; a new byte is
    // only loaded once the slot is empty, so strobes can never be back to back.
    assign strobe     = pend_q & ~bus.data_wait;
    assign slot_free  = ~pend_q;

    assign bus.data_strobe = strobe;
    assign bus.data        = data_q;
    assign bus.sdr_req     = req_q;
    assign bus.sdr_addr    = addr_q;
    assign busy            = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_CFG;
            ST_CFG:      if (slot_free) state_d = ST_REG_SEL;
            ST_REG_SEL: begin
                if (past_last) begin
                    state_d = ST_TERM;
                end else if (uploadable) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR:      if (slot_free && cnt_q == 2'd3) state_d = ST_FETCH;
            ST_FETCH:    state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: if (bus.sdr_rdy) state_d = ST_EMIT_LO;
            ST_EMIT_LO:  if (slot_free) state_d = (rem_q == 24'd1) ? ST_REG_SEL : ST_EMIT_HI;
            ST_EMIT_HI:  if (slot_free) state_d = (rem_q == 24'd1) ? ST_REG_SEL : ST_FETCH;
            ST_TERM:     if (slot_free && cnt_q == 2'd3) state_d = ST_DONE;
            ST_DONE:     if (strobe) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_d     = cfg_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        off_d     = off_q;
        base_d    = base_q;
        reorder_d = reorder_q;
        word_d    = word_q;
        req_d     = req_q;
        addr_d    = addr_q;
        load      = 1'b0;
        load_byte = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_d = board_cfg_byte;
                    idx_d = '0;
                end
            end
            ST_CFG: begin
                load      = slot_free;
                load_byte = cfg_q;
            end
            ST_REG_SEL: begin
                cnt_d = 2'd0;
                if (!past_last) begin
                    if (uploadable) begin
                        rem_d     = region.size;
                        off_d     = '0;
                        base_d    = region.base_addr;
                        reorder_d = region.reorder_64;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            ST_HDR: begin
                load = slot_free;
                case (cnt_q)
                    2'd0:    load_byte = 8'(idx_q);
                    2'd1:    load_byte = rem_q[23:16];
                    2'd2:    load_byte = rem_q[15:8];
                    default: load_byte = rem_q[7:0];
                endcase
                if (slot_free) cnt_d = cnt_q + 2'd1;
            end
            ST_FETCH: begin
                req_d  = 1'b1;
                addr_d = base_q + mapped;
            end
            ST_WAIT_RDY: begin
                if (bus.sdr_rdy) begin
                    word_d = bus.sdr_dout;
                    req_d  = 1'b0;
                end
            end
            ST_EMIT_LO, ST_EMIT_HI: begin
                load      = slot_free;
                load_byte = (state_q == ST_EMIT_HI) ? word_q[15:8] : word_q[7:0];
                if (slot_free) begin
                    off_d = off_q + 25'd1;
                    rem_d = rem_q - 24'd1;
                    if (rem_q == 24'd1) idx_d = idx_q + IDX_ONE;
                end
            end
            ST_TERM: begin
                load      = slot_free;
                load_byte = 8'h00;
                if (slot_free) cnt_d = cnt_q + 2'd1;
            end
            default: ;
        endcase

        data_d = load ? load_byte : data_q;
        pend_d = load | (pend_q & ~strobe);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            off_q     <= '0;
            base_q    <= '0;
            reorder_q <= 1'b0;
            word_q    <= '0;
            data_q    <= '0;
            pend_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            cfg_q     <= cfg_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            off_q     <= off_d;
            base_q    <= base_d;
            reorder_q <= reorder_d;
            word_q    <= word_d;
            data_q    <= data_d;
            pend_q    <= pend_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
        end
    end

endmodule

// File: tb/tb_rom_region_uploader.sv
// Directed bench for rom_region_uploader: SDR word model, stream capture and
// expected-stream construction from the board region table written out by hand.
module tb_rom_region_uploader;

    localparam int EXP_LEN  = 152;
    localparam int NUM_READS = 68;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] board_cfg_byte = 8'h00;
    logic       busy;

    rom_region_uploader_if bus_if ();

    rom_region_uploader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .board_cfg_byte (board_cfg_byte),
        .busy           (busy),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchecks++;
        assert (obs === expv) else begin
            nerrors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        if (a == 25'h0000100) return 16'h2211;
        if (a == 25'h0000102) return 16'h4433;
        return {~a[7:0], a[7:0]};
    endfunction

    function automatic logic [24:0] map_ref(input logic [24:0] n);
        logic [24:0] r;
        r      = n;
        r[2]   = n[6];
        r[6:3] = n[5:2];
        return r;
    endfunction

    // SDR read port model: answers each request after sdr_lat cycles of sdr_req.
    int          sdr_lat = 1;
    int          req_cnt = 0;
    logic [24:0] req_addr0 = '0;
    bit          addr_moved = 1'b0;
    logic [24:0] req_log[$];
    int          req_len[$];
    bit          req_moved[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            bus_if.sdr_rdy  = 1'b0;
            bus_if.sdr_dout = 16'h0000;
            req_cnt         = 0;
        end else if (bus_if.sdr_rdy) begin
            bus_if.sdr_rdy = 1'b0;
        end else if (bus_if.sdr_req) begin
            if (req_cnt == 0) begin
                req_addr0  = bus_if.sdr_addr;
                addr_moved = 1'b0;
            end else if (bus_if.sdr_addr !== req_addr0) begin
                addr_moved = 1'b1;
            end
            req_cnt++;
            if (req_cnt >= sdr_lat) begin
                bus_if.sdr_rdy  = 1'b1;
                bus_if.sdr_dout = mem_word(bus_if.sdr_addr);
                req_log.push_back(req_addr0);
                req_len.push_back(req_cnt);
                req_moved.push_back(addr_moved);
                req_cnt = 0;
            end
        end
    end

    // Stream capture with strobe protocol checks.
    logic [7:0] cap[$];
    bit         prev_strb = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_strb = 1'b0;
        end else begin
            if (bus_if.data_strobe) begin
                chk("strobe_during_wait", 32'(bus_if.data_wait), 32'd0);
                chk("strobe_back_to_back", 32'(prev_strb), 32'd0);
                cap.push_back(bus_if.data);
            end
            prev_strb = bus_if.data_strobe;
        end
    end

    logic [7:0] exp_q[$];

    task automatic build_exp(input logic [7:0] cfg);
        logic [159:0] head;
        logic [24:0]  a;
        logic [15:0]  w;
        exp_q.delete();
        head = {cfg,
                8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 8'hFF, 8'h02,
                8'h04, 8'h00, 8'h00, 8'h80};
        for (int i = 19; i >= 0; i--) exp_q.push_back(head[i*8 +: 8]);
        for (int n = 0; n < 128; n++) begin
            a = 25'h0010000 + map_ref(25'(n & ~1));
            w = mem_word(a);
            exp_q.push_back((n % 2 == 1) ? w[15:8] : w[7:0]);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        cap.delete();
        req_log.delete();
        req_len.delete();
        req_moved.delete();
    endtask

    task automatic start_and_latency(input logic [7:0] cfg);
        board_cfg_byte = cfg;
        start = 1'b1;
        tick();
        start = 1'b0;
        board_cfg_byte = ~cfg;
        chk("busy_after_start", 32'(busy), 32'd1);
        @(negedge clk);
        chk("no_strobe_cycle1", 32'(bus_if.data_strobe), 32'd0);
        tick();
        @(negedge clk);
        chk("strobe_cycle2", 32'(bus_if.data_strobe), 32'd1);
        chk("cfg_byte", 32'(bus_if.data), 32'(cfg));
        tick();
    endtask

    int nstr;
    bit last_busy;

    task automatic run_stream(input int hold_at, input bit start_at_last);
        int cyc       = 0;
        int last_cyc  = 0;
        int hold_left = 0;
        bit hold_req  = 1'b0;
        nstr      = cap.size();
        last_busy = 1'b0;
        while (busy && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (bus_if.data_strobe) begin
                nstr++;
                last_busy = busy;
                last_cyc  = cyc;
                if (nstr == hold_at) hold_req = 1'b1;
                if (nstr == 20) begin
                    board_cfg_byte = 8'h77;
                    start = 1'b1;
                end
                if (start_at_last && nstr == EXP_LEN) begin
                    board_cfg_byte = 8'hEE;
                    start = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (hold_req) begin
                bus_if.data_wait = 1'b1;
                hold_left = 10;
                hold_req  = 1'b0;
            end else if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) bus_if.data_wait = 1'b0;
            end
        end
        chk("stream_finished_in_budget", 32'(busy), 32'd0);
        chk("busy_at_last_strobe", 32'(last_busy), 32'd1);
        chk("busy_drop_after_last_strobe", 32'(cyc - last_cyc), 32'd0);
    endtask

    task automatic compare_stream();
        chk("stream_len", 32'(cap.size()), 32'(EXP_LEN));
        for (int i = 0; i < EXP_LEN && i < cap.size(); i++)
            chk($sformatf("stream_byte%0d", i), 32'(cap[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reads();
        int skipped = 0;
        chk("sdr_read_count", 32'(req_log.size()), 32'(NUM_READS));
        if (req_log.size() == NUM_READS) begin
            chk("rd_r0_w0", 32'(req_log[0]), 32'h0000100);
            chk("rd_r0_w1", 32'(req_log[1]), 32'h0000102);
            chk("rd_r3_w0", 32'(req_log[2]), 32'h0000200);
            chk("rd_r3_w1", 32'(req_log[3]), 32'h0000202);
            chk("rd_r4_n4", 32'(req_log[6]), 32'h0010008);
            chk("rd_r4_n64", 32'(req_log[36]), 32'h0010004);
            chk("rd_r4_n126", 32'(req_log[67]), 32'h001007E);
        end
        foreach (req_log[i])
            if (req_log[i] >= 25'h0001000 && req_log[i] < 25'h0001010) skipped++;
        chk("bram_region_not_read", 32'(skipped), 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int held;
        int bad_len;
        int moved;

        bus_if.data_wait = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobe", 32'(bus_if.data_strobe), 32'd0);
        chk("rst_req", 32'(bus_if.sdr_req), 32'd0);
        chk("rst_data", 32'(bus_if.data), 32'd0);
        chk("rst_addr", 32'(bus_if.sdr_addr), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();

        // Full upload, fast SDR, no back-pressure
        clear_logs();
        sdr_lat = 1;
        build_exp(8'h05);
        start_and_latency(8'h05);
        run_stream(0, 1'b0);
        compare_stream();
        check_reads();

        // Slow SDR, 10-cycle back-pressure mid-data, start on final strobe
        tick();
        clear_logs();
        sdr_lat = 7;
        build_exp(8'hA3);
        start_and_latency(8'hA3);
        run_stream(7, 1'b1);
        chk("idle_after_late_start", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("still_idle_after_late_start", 32'(busy), 32'd0);
        compare_stream();
        check_reads();
        bad_len = 0;
        moved   = 0;
        foreach (req_len[i]) if (req_len[i] != 7) bad_len++;
        foreach (req_moved[i]) if (req_moved[i]) moved++;
        chk("req_held_7_cycles", 32'(bad_len), 32'd0);
        chk("addr_stable_while_req", 32'(moved), 32'd0);

        // Reset during the second data byte
        sdr_lat = 1;
        tick();
        clear_logs();
        start_and_latency(8'h3C);
        n   = 1;
        cyc = 0;
        while (n < 7 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (bus_if.data_strobe) n++;
        end
        chk("reached_data_byte2", 32'(n), 32'd7);
        chk("data_byte2_value", 32'(bus_if.data), 32'h22);
        reset_n = 1'b0;
        #1;
        chk("arst_strobe", 32'(bus_if.data_strobe), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req", 32'(bus_if.sdr_req), 32'd0);
        chk("arst_data", 32'(bus_if.data), 32'd0);
        chk("arst_addr", 32'(bus_if.sdr_addr), 32'd0);
        held = cap.size();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) tick();
        chk("no_strobe_after_abort", 32'(cap.size()), 32'(held));
        chk("idle_after_abort", 32'(busy), 32'd0);

        // Fresh upload after the abort
        clear_logs();
        build_exp(8'h3C);
        start_and_latency(8'h3C);
        run_stream(0, 1'b0);
        compare_stream();
        check_reads();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
